trapezoid_job_sched: RTL and testbench
======================================

# trapezoid_job_sched

Job scheduler and arbiter in front of the trapezoid renderer. It accepts complete trapezoid jobs (four packed vertices) from two requesters and grants between them round-robin. It serialises the winning job onto the renderer's nt/xi/yi vertex port, tracks the renderer through busy/po, counts emitted pixels, and reports one completion record per job.

## Interface
Parameters:
- CNT_W, 16, width of per-job pixel counter
- TIMEOUT, 4096, watchdog limit in cycles; used only when TRAP_SCHED_TIMEOUT_EN is defined

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has a job
- req0_ready / req1_ready  out  1  job accepted this cycle when valid&ready
- req0_x / req1_x  in  32  x of vertices 0..3; vertex k in bits [31-8k:24-8k]
- req0_y / req1_y  in  32  y of vertices 0..3, same packing
- render_nt  out  1  new-trapezoid strobe to renderer
- render_xi, render_yi  out  8  vertex coordinate to renderer
- render_busy  in  1  renderer busy
- render_po  in  1  renderer pixel-out strobe
- done_valid  out  1  one-cycle completion pulse
- done_id  out  1  requester that owned the finished job
- done_pix  out  CNT_W  pixels counted for that job
- done_err  out  1  job ended by watchdog
- sched_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SEND, WAIT_BUSY, RENDER, DONE.
- IDLE: accept only when render_busy=0. Grant is round-robin. If both requesters are valid, grant the one not served last. After reset, the pointer favours req0. reqN_ready=1 combinationally only for the grantee while in IDLE with render_busy=0. On valid&ready, latch x/y/id, clear the pixel counter, and go to SEND.
- SEND: 4 cycles driven by a 2-bit index k=0..3. render_xi/yi = vertex k. render_nt=1 only when k=0. After k=3, go to WAIT_BUSY.
- WAIT_BUSY: hold until render_busy=1, then go to RENDER.
- RENDER: each cycle with render_po=1 increments the counter, which saturates at 2^CNT_W-1. When render_busy=0, go to DONE. A po in the same cycle that busy falls is still counted.
- DONE: done_valid=1 for one cycle with done_id, done_pix and done_err. Update the round-robin pointer to done_id. Return to IDLE.
- render_po outside RENDER is ignored.
- Reset mid-job: return to IDLE. The job is dropped with no done pulse, and the pointer returns to favour req0.

## Timing
- Reset values: all outputs 0; req ready 0; render_xi/yi 0; state IDLE.
- Handshake to first vertex: accept at edge T; render_nt=1 with vertex 0 in cycle T+1; vertex 3 in cycle T+4.
- Render outputs are registered. done_* are registered and valid only while done_valid=1.
- Minimum turnaround from busy falling to the next accept is 2 cycles (DONE, then IDLE).
- No job is accepted while render_busy=1 in IDLE (the renderer is still in its own reset/finish).

## Configuration
- TRAP_SCHED_TIMEOUT_EN defined: a watchdog counter runs in WAIT_BUSY and RENDER and clears on entry to WAIT_BUSY. When it reaches TIMEOUT, go to DONE with done_err=1 and done_pix equal to the count so far.
- TRAP_SCHED_TIMEOUT_EN undefined: no watchdog logic; waits are unbounded; done_err is tied to 0.

## Test plan
- Single job on req0 with x=0x0A140A14, y=0x0A0A0505 -> render_nt in cycle T+1; xi sequence 0A,14,0A,14 and yi sequence 0A,0A,05,05; after busy falls, done_valid=1, done_id=0, done_pix equals the number of po cycles.
- Both requesters valid continuously for 4 jobs -> grant order 0,1,0,1; exactly one ready high per accept.
- Requester valid while render_busy=1 in IDLE -> ready stays 0 until busy=0.
- po asserted in the cycle busy falls, and po in IDLE -> the first is counted, the second is ignored.
- Reset asserted during SEND at k=2 -> next cycle: nt=0, xi/yi=0, no done pulse; next job is granted to req0.
- TRAP_SCHED_TIMEOUT_EN with TIMEOUT=16 and render_busy never rising -> done_valid with done_err=1 and done_pix=0 at 16 cycles after entering WAIT_BUSY.

Source files
------------

// File: rtl/trapezoid_job_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : trapezoid_job_sched                                         |
// | Description : Two-requester round-robin job scheduler for the trapezoid   |
// |               renderer. Serialises four packed vertices onto the         |
// |               nt/xi/yi port, tracks busy/po, counts pixels and reports   |
// |               one completion record per job.                             |
// | Options     : define TRAP_SCHED_TIMEOUT_EN to enable the watchdog         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module trapezoid_job_sched #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_x,
  input  logic [31:0]      req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_x,
  input  logic [31:0]      req1_y,
  output logic             render_nt,
  output logic [7:0]       render_xi,
  output logic [7:0]       render_yi,
  input  logic             render_busy,
  input  logic             render_po,
  output logic             done_valid,
  output logic             done_id,
  output logic [CNT_W-1:0] done_pix,
  output logic             done_err,
  output logic             sched_busy
);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_SEND      = 3'd1;
  localparam logic [2:0] c_WAIT_BUSY = 3'd2;
  localparam logic [2:0] c_RENDER    = 3'd3;
  localparam logic [2:0] c_DONE      = 3'd4;

  logic [2:0]       r_state;
  logic [1:0]       r_k;
  logic [31:0]      r_x;
  logic [31:0]      r_y;
  logic             r_id;
  logic             r_last;      // requester served last; reset value 1 favours req0
  logic [CNT_W-1:0] r_cnt;
  logic             r_nt;
  logic [7:0]       r_xi;
  logic [7:0]       r_yi;
  logic             r_done_valid;
  logic             r_done_id;
  logic [CNT_W-1:0] r_done_pix;

  logic             w_idle_open;
  logic             w_gnt;
  logic             w_accept;
  logic [1:0]       w_k_next;
  logic [7:0]       w_xv;
  logic [7:0]       w_yv;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_timeout_hit;
  logic             w_enter_done;

  // Round-robin grant: with both valid, serve the one not served last
  always_comb begin
    w_idle_open = (r_state == c_IDLE) && !render_busy;
    w_gnt       = req0_valid ? (req1_valid ? ~r_last : 1'b0) : 1'b1;
    w_accept    = w_idle_open && (req0_valid || req1_valid);
  end

  assign req0_ready = w_idle_open & req0_valid & ~w_gnt;
  assign req1_ready = w_idle_open & req1_valid & w_gnt;

  // Next vertex to present while walking through SEND
  always_comb begin
    w_k_next = r_k + 2'd1;
    case (w_k_next)
      2'd0:    begin w_xv = r_x[31:24]; w_yv = r_y[31:24]; end
      2'd1:    begin w_xv = r_x[23:16]; w_yv = r_y[23:16]; end
      2'd2:    begin w_xv = r_x[15:8];  w_yv = r_y[15:8];  end
      default: begin w_xv = r_x[7:0];   w_yv = r_y[7:0];   end
    endcase
  end

  // Saturating pixel count including this cycle's strobe
  always_comb begin
    w_cnt_next = r_cnt;
    if (render_po && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

`ifdef TRAP_SCHED_TIMEOUT_EN
  logic [31:0] r_wd;
  logic        r_done_err;

  assign w_timeout_hit = ((r_state == c_WAIT_BUSY) || (r_state == c_RENDER)) &&
                         (r_wd == 32'(TIMEOUT - 1));

  // Watchdog runs only while waiting on the renderer; held at zero elsewhere
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd <= '0;
    end else if ((r_state == c_WAIT_BUSY) || (r_state == c_RENDER)) begin
      r_wd <= r_wd + 32'd1;
    end else begin
      r_wd <= '0;
    end
  end

  // Error flag accompanies the completion record of a timed-out job
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_err <= 1'b0;
    end else begin
      r_done_err <= w_timeout_hit;
    end
  end

  assign done_err = r_done_err;
`else
  wire w_unused_timeout = (TIMEOUT != 0);

  assign w_timeout_hit = 1'b0;
  assign done_err      = 1'b0;
`endif

  assign w_enter_done = w_timeout_hit || ((r_state == c_RENDER) && !render_busy);

  // Main job FSM; render and done outputs are registered and default low
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_k          <= 2'd0;
      r_x          <= '0;
      r_y          <= '0;
      r_id         <= 1'b0;
      r_last       <= 1'b1;
      r_cnt        <= '0;
      r_nt         <= 1'b0;
      r_xi         <= 8'h00;
      r_yi         <= 8'h00;
      r_done_valid <= 1'b0;
      r_done_id    <= 1'b0;
      r_done_pix   <= '0;
    end else begin
      r_nt         <= 1'b0;
      r_xi         <= 8'h00;
      r_yi         <= 8'h00;
      r_done_valid <= 1'b0;
      r_done_id    <= 1'b0;
      r_done_pix   <= '0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_x     <= w_gnt ? req1_x : req0_x;
            r_y     <= w_gnt ? req1_y : req0_y;
            r_id    <= w_gnt;
            r_cnt   <= '0;
            r_k     <= 2'd0;
            r_nt    <= 1'b1;
            r_xi    <= w_gnt ? req1_x[31:24] : req0_x[31:24];
            r_yi    <= w_gnt ? req1_y[31:24] : req0_y[31:24];
            r_state <= c_SEND;
          end
        end
        c_SEND: begin
          if (r_k == 2'd3) begin
            r_state <= c_WAIT_BUSY;
          end else begin
            r_k  <= w_k_next;
            r_xi <= w_xv;
            r_yi <= w_yv;
          end
        end
        c_WAIT_BUSY, c_RENDER: begin
          if (r_state == c_RENDER) begin
            r_cnt <= w_cnt_next;
          end
          if (w_enter_done) begin
            r_state      <= c_DONE;
            r_done_valid <= 1'b1;
            r_done_id    <= r_id;
            r_done_pix   <= (r_state == c_RENDER) ? w_cnt_next : r_cnt;
          end else if ((r_state == c_WAIT_BUSY) && render_busy) begin
            r_state <= c_RENDER;
          end
        end
        c_DONE: begin
          r_last  <= r_id;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign render_nt  = r_nt;
  assign render_xi  = r_xi;
  assign render_yi  = r_yi;
  assign done_valid = r_done_valid;
  assign done_id    = r_done_id;
  assign done_pix   = r_done_pix;
  assign sched_busy = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trapezoid_job_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_trapezoid_job_sched                                      |
// | Description : Self-checking bench: directed job scenarios plus random     |
// |               traffic compared each cycle against a job-level model.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_trapezoid_job_sched;
  localparam int CW = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0]   req0_x, req0_y, req1_x, req1_y;
  logic          render_nt;
  logic [7:0]    render_xi, render_yi;
  logic          render_busy, render_po;
  logic          done_valid, done_id, done_err, sched_busy;
  logic [CW-1:0] done_pix;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [7:0] ex [4] = '{8'h0A, 8'h14, 8'h0A, 8'h14};
  logic [7:0] ey [4] = '{8'h0A, 8'h0A, 8'h05, 8'h05};
  int         order [4] = '{0, 1, 0, 1};

  trapezoid_job_sched #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .render_nt(render_nt), .render_xi(render_xi), .render_yi(render_yi),
    .render_busy(render_busy), .render_po(render_po),
    .done_valid(done_valid), .done_id(done_id), .done_pix(done_pix),
    .done_err(done_err), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- job-level reference model ----------------
  int          m_send = -1;   // vertex index shown this cycle, -1 when not sending
  bit          m_wait = 1'b0, m_rend = 1'b0, m_done = 1'b0;
  bit          m_last = 1'b1, m_id = 1'b0, m_err = 1'b0;
  logic [31:0] m_x = '0, m_y = '0;
  int          m_pix = 0, m_wd = 0;

  function automatic bit m_idle();
    return (m_send < 0) && !m_wait && !m_rend && !m_done;
  endfunction

  function automatic int m_gnt();
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit exp_rdy(input int n);
    return m_idle() && !render_busy && (m_gnt() == n);
  endfunction

  function automatic logic [7:0] vb(input logic [31:0] w, input int k);
    return w[31-8*k -: 8];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_send <= -1; m_wait <= 1'b0; m_rend <= 1'b0; m_done <= 1'b0;
      m_last <= 1'b1; m_wd <= 0;
    end else if (m_done) begin
      m_last <= m_id;
      m_done <= 1'b0;
    end else if (m_wait || m_rend) begin : adv
      int p;
      bit fin;
      p   = m_pix;
      fin = 1'b0;
      if (m_rend && render_po && (p < (1 << CW) - 1)) p++;
      m_pix <= p;
`ifdef TRAP_SCHED_TIMEOUT_EN
      if (m_wd + 1 >= TO) begin
        fin = 1'b1;
        m_err <= 1'b1; m_done <= 1'b1; m_wait <= 1'b0; m_rend <= 1'b0;
      end
      m_wd <= m_wd + 1;
`endif
      if (!fin) begin
        if (m_wait && render_busy) begin
          m_wait <= 1'b0; m_rend <= 1'b1;
        end else if (m_rend && !render_busy) begin
          m_rend <= 1'b0; m_done <= 1'b1; m_err <= 1'b0;
        end
      end
    end else if (m_send >= 0) begin
      if (m_send == 3) begin
        m_send <= -1; m_wait <= 1'b1; m_wd <= 0;
      end else begin
        m_send <= m_send + 1;
      end
    end else if (!render_busy && (m_gnt() >= 0)) begin
      m_id   <= (m_gnt() == 1);
      m_x    <= (m_gnt() == 1) ? req1_x : req0_x;
      m_y    <= (m_gnt() == 1) ? req1_y : req0_y;
      m_pix  <= 0;
      m_err  <= 1'b0;
      m_send <= 0;
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready0", 32'(req0_ready), 32'(exp_rdy(0)));
      chk("m_ready1", 32'(req1_ready), 32'(exp_rdy(1)));
      chk("m_nt", 32'(render_nt), 32'(m_send == 0));
      chk("m_xi", 32'(render_xi), 32'((m_send >= 0) ? vb(m_x, m_send) : 8'h00));
      chk("m_yi", 32'(render_yi), 32'((m_send >= 0) ? vb(m_y, m_send) : 8'h00));
      chk("m_sched_busy", 32'(sched_busy), 32'(!m_idle()));
      chk("m_done_valid", 32'(done_valid), 32'(m_done));
      if (m_done) begin
        chk("m_done_id", 32'(done_id), 32'(m_id));
        chk("m_done_pix", 32'(done_pix), 32'(m_pix));
        chk("m_done_err", 32'(done_err), 32'(m_err));
      end
    end
  end

  // Called in the first SEND cycle; plays a renderer emitting npo pixels
  task automatic finish_job(input int npo, output logic dv, output logic di,
                            output logic [CW-1:0] dp);
    render_po = 1'b0;
    repeat (4) tick();
    render_busy = 1'b1;
    tick();
    for (int i = 0; i < npo; i++) begin
      render_po = 1'b1;
      tick();
    end
    render_busy = 1'b0;
    render_po   = 1'b0;
    tick();
    @(negedge clk);
    dv = done_valid; di = done_id; dp = done_pix;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic          dv, di;
    logic [CW-1:0] dp;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    render_busy = 1'b0; render_po = 1'b0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_nt", 32'(render_nt), 0);
    chk("rst_xi", 32'(render_xi), 0);
    chk("rst_done", 32'(done_valid), 0);
    chk("rst_busy", 32'(sched_busy), 0);
    tick();

    // single job on req0 with known vertices; po counted as busy falls
    req0_x = 32'h0A140A14; req0_y = 32'h0A0A0505; req0_valid = 1'b1;
    @(negedge clk);
    chk("t1_ready0", 32'(req0_ready), 1);
    chk("t1_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_nt", 32'(render_nt), 32'(k == 0));
      chk("t1_xi", 32'(render_xi), 32'(ex[k]));
      chk("t1_yi", 32'(render_yi), 32'(ey[k]));
      tick();
    end
    render_busy = 1'b1; render_po = 1'b1;
    tick();
    render_po = 1'b1; tick();
    render_po = 1'b0; tick();
    render_po = 1'b1; tick();
    render_po = 1'b1; tick();
    render_busy = 1'b0; render_po = 1'b1; tick();
    @(negedge clk);
    chk("t1_done_valid", 32'(done_valid), 1);
    chk("t1_done_id", 32'(done_id), 0);
    chk("t1_done_pix", 32'(done_pix), 4);
    chk("t1_done_err", 32'(done_err), 0);
    tick();

    // po in IDLE ignored; req1 alone, no pixels
    req1_valid = 1'b1; req1_x = 32'h11223344; req1_y = 32'h55667788;
    @(negedge clk);
    chk("t2_ready1", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    finish_job(0, dv, di, dp);
    chk("t2_done_valid", 32'(dv), 1);
    chk("t2_done_id", 32'(di), 1);
    chk("t2_done_pix", 32'(dp), 0);

    // both requesters valid for four jobs: alternate grants
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_x = $urandom; req0_y = $urandom; req1_x = $urandom; req1_y = $urandom;
      @(negedge clk);
      chk("t3_one_ready", 32'(req0_ready) + 32'(req1_ready), 1);
      chk("t3_grant", 32'(req1_ready), 32'(order[i]));
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      finish_job(i + 1, dv, di, dp);
      chk("t3_done_id", 32'(di), 32'(order[i]));
      chk("t3_done_pix", 32'(dp), 32'(i + 1));
    end

    // no accept while renderer busy in IDLE; then saturating count
    render_busy = 1'b1; req0_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_ready_blocked", 32'(req0_ready), 0);
      tick();
    end
    render_busy = 1'b0;
    @(negedge clk);
    chk("t4_ready_open", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    finish_job(9, dv, di, dp);
    chk("t4_done_id", 32'(di), 0);
    chk("t4_done_pix_sat", 32'(dp), 7);

    // reset during SEND at k=2 drops the job and re-favours req0
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("t5_nt", 32'(render_nt), 0);
    chk("t5_xi", 32'(render_xi), 0);
    chk("t5_yi", 32'(render_yi), 0);
    chk("t5_done", 32'(done_valid), 0);
    chk("t5_ready0", 32'(req0_ready), 1);
    chk("t5_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    finish_job(1, dv, di, dp);
    chk("t5_done_id", 32'(di), 0);
    chk("t5_done_pix", 32'(dp), 1);

`ifdef TRAP_SCHED_TIMEOUT_EN
    // watchdog: renderer never goes busy
    begin
      bit got;
      int n;
      got = 1'b0; n = -1;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      repeat (4) tick();
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (done_valid) begin
          got = 1'b1; n = c; dp = done_pix; di = done_err;
        end
        tick();
      end
      chk("t6_timeout_seen", 32'(got), 1);
      chk("t6_timeout_cycle", 32'(n), TO);
      chk("t6_timeout_err", 32'(di), 1);
      chk("t6_timeout_pix", 32'(dp), 0);
    end
`endif

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req0_valid  = 1'($urandom_range(0, 1));
      req1_valid  = 1'($urandom_range(0, 1));
      req0_x = $urandom; req0_y = $urandom; req1_x = $urandom; req1_y = $urandom;
      render_busy = ($urandom_range(0, 3) != 0);
      render_po   = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    render_busy = 1'b0; render_po = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
